// File: rtl/spi_pkg.sv
// Constants and types shared by the SPI master and slave endpoints.
package spi_pkg;

    localparam int unsigned SPI_DATA_W = 6;

    localparam logic [2:0] SS_NONE = 3'b111;
    localparam logic [2:0] SLAVE_1 = 3'b000;
    localparam logic [2:0] SLAVE_2 = 3'b001;
    localparam logic [2:0] SLAVE_3 = 3'b010;

    // Action taken by the slave on a given sclk edge, decoded from sel and cnt.
    typedef enum logic [1:0] {
        ActIdle,
        ActShift,
        ActEnd,
        ActAbort
    } spi_act_e;

endpackage

// File: rtl/spi_rx_hold.sv
// One-entry valid/ready holding register for received SPI frames, with overrun detection.
module spi_rx_hold #(
    parameter int unsigned DATA_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_word_valid,
    input  logic [DATA_W-1:0] i_word,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_overrun
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_overrun;

    logic [DATA_W-1:0] w_data_next;
    logic              w_valid_next;
    logic              w_overrun_next;

    always_comb begin
        w_data_next    = r_data;
        w_valid_next   = r_valid;
        w_overrun_next = 1'b0;
        if (i_word_valid) begin
            // A frame ending while the consumer is taking the old one still fits.
            if (!r_valid || i_ready) begin
                w_data_next  = i_word;
                w_valid_next = 1'b1;
            end else begin
                w_overrun_next = 1'b1;
            end
        end else if (r_valid && i_ready) begin
            w_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_data    <= w_data_next;
            r_valid   <= w_valid_next;
            r_overrun <= w_overrun_next;
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint: ss-code selected, MSB-first full-duplex shift with a one-entry
// transmit load buffer and a valid/ready receive port.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned       DATA_W    = SPI_DATA_W,
    parameter logic [2:0]        SLAVE_ID  = SLAVE_1,
    parameter logic [DATA_W-1:0] IDLE_FILL = '0
) (
    input  logic              sclk,
    input  logic              reset,
    input  logic [2:0]        ss,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              overrun,
    output logic              abort
);

    localparam int unsigned     CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] r_tx_hold;
    logic [DATA_W-1:0] r_tx_buf;
    logic              r_tx_pending;
    logic              r_abort;

    logic [CNT_W-1:0]  w_cnt_next;
    logic [DATA_W-1:0] w_shreg_next;
    logic [DATA_W-1:0] w_tx_hold_next;
    logic [DATA_W-1:0] w_tx_buf_next;
    logic              w_tx_pending_next;
    logic              w_abort_next;

    logic              w_sel;
    spi_act_e          w_act;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_reload;
    logic              w_frame_end;

    assign w_sel       = (ss == SLAVE_ID);
    assign w_shifted   = {r_shreg[DATA_W-2:0], mosi};
    assign w_reload    = r_tx_pending ? r_tx_buf : IDLE_FILL;
    assign w_frame_end = (w_act == ActEnd);

    always_comb begin
        w_act = ActIdle;
        if (w_sel) begin
            w_act = (r_cnt == CNT_LAST) ? ActEnd : ActShift;
        end else if (r_cnt != '0) begin
            // Includes ss moving to another slave's code mid-frame.
            w_act = ActAbort;
        end
    end

    always_comb begin
        w_cnt_next        = r_cnt;
        w_shreg_next      = r_shreg;
        w_tx_hold_next    = r_tx_hold;
        w_tx_buf_next     = r_tx_buf;
        w_tx_pending_next = r_tx_pending;
        w_abort_next      = 1'b0;

        case (w_act)
            ActShift: begin
                w_cnt_next   = r_cnt + CNT_W'(1);
                w_shreg_next = w_shifted;
            end
            ActEnd: begin
                w_cnt_next        = '0;
                w_shreg_next      = w_reload;
                w_tx_hold_next    = w_reload;
                w_tx_pending_next = 1'b0;
            end
            ActAbort: begin
                // Rewind so the interrupted frame is sent again from its MSB.
                w_cnt_next   = '0;
                w_shreg_next = r_tx_hold;
                w_abort_next = 1'b1;
            end
            ActIdle: begin
                if (r_tx_pending) begin
                    w_shreg_next      = r_tx_buf;
                    w_tx_hold_next    = r_tx_buf;
                    w_tx_pending_next = 1'b0;
                end
            end
            default: begin
                w_cnt_next = '0;
            end
        endcase

        // Loads only land in an empty buffer, so they never collide with a transfer.
        if (tx_load && !r_tx_pending) begin
            w_tx_buf_next     = tx_data;
            w_tx_pending_next = 1'b1;
        end
    end

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_shreg      <= IDLE_FILL;
            r_tx_hold    <= IDLE_FILL;
            r_tx_buf     <= '0;
            r_tx_pending <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_next;
            r_shreg      <= w_shreg_next;
            r_tx_hold    <= w_tx_hold_next;
            r_tx_buf     <= w_tx_buf_next;
            r_tx_pending <= w_tx_pending_next;
            r_abort      <= w_abort_next;
        end
    end

    spi_rx_hold #(
        .DATA_W (DATA_W)
    ) u_rx_hold (
        .clk          (sclk),
        .rst          (reset),
        .i_word_valid (w_frame_end),
        .i_word       (w_shifted),
        .i_ready      (rx_ready),
        .o_data       (rx_data),
        .o_valid      (rx_valid),
        .o_overrun    (overrun)
    );

    assign miso     = w_sel ? r_shreg[DATA_W-1] : 1'b0;
    assign tx_ready = !r_tx_pending;
    assign busy     = (r_cnt != '0);
    assign abort    = r_abort;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: vector table for frame exchange plus hand-written
// sequences for abort, overrun, other-slave traffic and mid-frame reset.
module tb_spi_slave;

    logic       sclk;
    logic       reset;
    logic [2:0] ss;
    logic       mosi;
    logic       miso;
    logic [5:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [5:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy;
    logic       overrun;
    logic       abort;

    int checks   = 0;
    int failures = 0;

    spi_slave #(
        .DATA_W    (6),
        .SLAVE_ID  (3'b010),
        .IDLE_FILL (6'b000000)
    ) dut (
        .sclk     (sclk),
        .reset    (reset),
        .ss       (ss),
        .mosi     (mosi),
        .miso     (miso),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .busy     (busy),
        .overrun  (overrun),
        .abort    (abort)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    typedef struct {
        logic [2:0] ss;
        logic       mosi;
        logic       ld;
        logic [5:0] txd;
        logic       rdy;
        logic       e_miso;   // before the edge
        logic       e_txr;    // after the edge
        logic       e_busy;
        logic       e_rxv;
        logic [5:0] e_rxd;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    // One selected frame; rx_ready is rdy_mid except on the final edge.
    task automatic frame(input string nm, input logic [5:0] mosi_w, input logic [5:0] exp_miso,
                         input logic rdy_mid, input logic rdy_last);
        for (int i = 0; i < 6; i++) begin
            ss       = 3'b010;
            mosi     = mosi_w[5-i];
            tx_load  = 1'b0;
            rx_ready = (i == 5) ? rdy_last : rdy_mid;
            #1;
            chk($sformatf("%s miso bit%0d", nm, i), {31'd0, miso}, {31'd0, exp_miso[5-i]});
            tick();
            if (i < 5) chk($sformatf("%s busy edge%0d", nm, i + 1), {31'd0, busy}, 32'd1);
        end
    endtask

    task automatic idle_tick(input logic rdy);
        ss       = 3'b111;
        mosi     = 1'b0;
        tx_load  = 1'b0;
        rx_ready = rdy;
        tick();
    endtask

    initial begin
        reset    = 1'b1;
        ss       = 3'b111;
        mosi     = 1'b0;
        tx_data  = 6'd0;
        tx_load  = 1'b0;
        rx_ready = 1'b1;

        //            ss      mosi  ld    txd        rdy   miso  txr   busy  rxv   rxd
        vecs[0]  = '{3'b111, 1'b0, 1'b1, 6'b110011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
        vecs[1]  = '{3'b111, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b000000};
        vecs[2]  = '{3'b010, 1'b1, 1'b1, 6'b000111, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'b000000};
        vecs[3]  = '{3'b010, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'b000000};
        vecs[4]  = '{3'b010, 1'b1, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000000};
        vecs[5]  = '{3'b010, 1'b1, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000000};
        vecs[6]  = '{3'b010, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'b000000};
        vecs[7]  = '{3'b010, 1'b1, 1'b0, 6'b000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'b101101};
        vecs[8]  = '{3'b010, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'b101101};
        vecs[9]  = '{3'b010, 1'b1, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'b101101};
        vecs[10] = '{3'b010, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'b101101};
        vecs[11] = '{3'b010, 1'b1, 1'b0, 6'b000000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'b101101};
        vecs[12] = '{3'b010, 1'b1, 1'b0, 6'b000000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'b101101};
        vecs[13] = '{3'b010, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'b010110};
        vecs[14] = '{3'b111, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b010110};

        repeat (2) @(posedge sclk);
        #1;
        chk("reset miso", {31'd0, miso}, 32'd0);
        chk("reset rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset rx_data", {26'd0, rx_data}, 32'd0);
        reset = 1'b0;

        // Load, full frame exchange, then a back-to-back frame with no gap edge.
        for (int i = 0; i < 15; i++) begin
            ss       = vecs[i].ss;
            mosi     = vecs[i].mosi;
            tx_load  = vecs[i].ld;
            tx_data  = vecs[i].txd;
            rx_ready = vecs[i].rdy;
            #1;
            chk($sformatf("row%0d miso", i), {31'd0, miso}, {31'd0, vecs[i].e_miso});
            tick();
            chk($sformatf("row%0d tx_ready", i), {31'd0, tx_ready}, {31'd0, vecs[i].e_txr});
            chk($sformatf("row%0d busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
            chk($sformatf("row%0d rx_valid", i), {31'd0, rx_valid}, {31'd0, vecs[i].e_rxv});
            chk($sformatf("row%0d rx_data", i), {26'd0, rx_data}, {26'd0, vecs[i].e_rxd});
            chk($sformatf("row%0d overrun", i), {31'd0, overrun}, 32'd0);
            chk($sformatf("row%0d abort", i), {31'd0, abort}, 32'd0);
        end
        tx_load = 1'b0;

        // Abort after three edges, then the same frame is resent from its MSB.
        ss = 3'b111; tx_load = 1'b1; tx_data = 6'b110011; rx_ready = 1'b0;
        tick();
        idle_tick(1'b0);
        chk("abort setup tx_ready", {31'd0, tx_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            ss   = 3'b010;
            mosi = 1'b1;
            tick();
        end
        chk("abort pre busy", {31'd0, busy}, 32'd1);
        ss = 3'b111;
        #1;
        chk("abort deselected miso", {31'd0, miso}, 32'd0);
        tick();
        chk("abort pulse", {31'd0, abort}, 32'd1);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort rx_valid", {31'd0, rx_valid}, 32'd0);
        idle_tick(1'b0);
        chk("abort pulse ends", {31'd0, abort}, 32'd0);
        frame("resend", 6'b111000, 6'b110011, 1'b0, 1'b0);
        chk("resend rx_valid", {31'd0, rx_valid}, 32'd1);
        chk("resend rx_data", {26'd0, rx_data}, {26'd0, 6'b111000});
        chk("resend no abort", {31'd0, abort}, 32'd0);

        // Second frame with rx_ready low is dropped.
        frame("ovr", 6'b010101, 6'b000000, 1'b0, 1'b0);
        chk("ovr pulse", {31'd0, overrun}, 32'd1);
        chk("ovr rx_data kept", {26'd0, rx_data}, {26'd0, 6'b111000});
        chk("ovr rx_valid", {31'd0, rx_valid}, 32'd1);
        idle_tick(1'b0);
        chk("ovr pulse ends", {31'd0, overrun}, 32'd0);

        // Consume and refill on the same frame-end edge.
        frame("simul", 6'b001100, 6'b000000, 1'b0, 1'b1);
        chk("simul rx_data", {26'd0, rx_data}, {26'd0, 6'b001100});
        chk("simul rx_valid", {31'd0, rx_valid}, 32'd1);
        chk("simul no overrun", {31'd0, overrun}, 32'd0);
        idle_tick(1'b1);
        chk("simul consumed", {31'd0, rx_valid}, 32'd0);

        // Traffic for another slave leaves this one untouched.
        for (int i = 0; i < 2; i++) begin
            ss   = 3'b000;
            mosi = 1'b1;
            #1;
            chk($sformatf("other miso%0d", i), {31'd0, miso}, 32'd0);
            tick();
            chk($sformatf("other busy%0d", i), {31'd0, busy}, 32'd0);
        end
        frame("after_other", 6'b110110, 6'b000000, 1'b0, 1'b0);
        chk("after_other rx_data", {26'd0, rx_data}, {26'd0, 6'b110110});
        chk("after_other rx_valid", {31'd0, rx_valid}, 32'd1);

        // Reset arriving before the fourth edge of a frame.
        ss = 3'b111; tx_load = 1'b1; tx_data = 6'b101010;
        tick();
        idle_tick(1'b0);
        for (int i = 0; i < 3; i++) begin
            ss   = 3'b010;
            mosi = 1'b1;
            #1;
            chk($sformatf("prerst miso%0d", i), {31'd0, miso}, {31'd0, (i != 1)});
            tick();
        end
        reset = 1'b1;
        #1;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst rx_data", {26'd0, rx_data}, 32'd0);
        chk("rst tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst miso", {31'd0, miso}, 32'd0);
        idle_tick(1'b1);
        reset = 1'b0;
        idle_tick(1'b1);
        frame("postrst", 6'b100110, 6'b000000, 1'b1, 1'b1);
        chk("postrst rx_data", {26'd0, rx_data}, {26'd0, 6'b100110});
        chk("postrst rx_valid", {31'd0, rx_valid}, 32'd1);
        chk("postrst busy", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

Serial SPI slave endpoint that sits directly downstream of `spi_master` on the shared `sclk`/`ss` bus. It responds when the 3-bit `ss` code equals its `SLAVE_ID`, shifts in a `DATA_W`-bit frame on `mosi` (MSB first), and simultaneously shifts out a preloaded frame on `miso`. Received frames go to the local logic through a valid/ready port; transmit frames come in through a one-entry load buffer. Each bus position is one instance with a distinct `SLAVE_ID`.

## Interface
- `DATA_W`, 6: frame width in bits (≥2).
- `SLAVE_ID`, 3'b000: `ss` code that selects this slave. 3'b111 is reserved as "no slave".
- `IDLE_FILL`, 6'b000000: frame sent when no transmit data is pending.

- `sclk`  in  1  single clock, rising-edge only.
- `reset`  in  1  asynchronous, active-high.
- `ss`  in  3  slave-select code from the master.
- `mosi`  in  1  serial data from the master.
- `miso`  out  1  serial data to the master.
- `tx_data`  in  DATA_W  next frame to transmit.
- `tx_load`  in  1  write strobe for `tx_data`.
- `tx_ready`  out  1  transmit buffer empty.
- `rx_data`  out  DATA_W  last received frame.
- `rx_valid`  out  1  `rx_data` holds an unconsumed frame.
- `rx_ready`  in  1  consumer accepts `rx_data`.
- `busy`  out  1  mid-frame (`cnt != 0`).
- `overrun`  out  1  one-cycle pulse: a completed frame was dropped.
- `abort`  out  1  one-cycle pulse: deselected mid-frame.

## Operation
- Select: `sel = (ss == SLAVE_ID)`.
- State is implied by `cnt` (0..DATA_W-1):
  - IDLE: `cnt==0 && !sel`.
  - SHIFT: `sel`, or `cnt != 0`.
- `miso = sel ? shreg[DATA_W-1] : 1'b0`. The combinational MSB is valid before the first edge.
- Each edge with `sel`:
  - `shreg <= {shreg[DATA_W-2:0], mosi}`.
  - `cnt <= cnt + 1`.
- Frame end (edge with `sel && cnt==DATA_W-1`):
  - Received word is `{shreg[DATA_W-2:0], mosi}`.
  - `cnt <= 0`.
  - `shreg` and `tx_hold` reload with `tx_buf` if `tx_pending`, else `IDLE_FILL`. `tx_pending` clears.
  - If `sel` is still asserted on the next edge, the next frame starts with no gap.
- Idle reload: on any edge in IDLE with `tx_pending`:
  - `shreg <= tx_buf`, `tx_hold <= tx_buf`.
  - `tx_pending <= 0`.
- Transmit buffer:
  - `tx_ready = !tx_pending`.
  - `tx_load && tx_ready` captures `tx_data` and sets `tx_pending`.
  - `tx_load` while `!tx_ready` is ignored.
  - A load and a transfer can never happen on the same edge.
- Receive handshake:
  - Edge with `rx_valid && rx_ready` consumes the frame: `rx_valid <= 0` unless a frame ends on the same edge.
  - Frame end with `!rx_valid`, or with `rx_valid && rx_ready`: `rx_data <= word`, `rx_valid <= 1`.
  - Frame end with `rx_valid && !rx_ready`: word dropped, `rx_data` unchanged, `overrun` pulses.
- Abort (edge with `!sel && cnt != 0`):
  - `cnt <= 0`; the partial word is discarded.
  - `shreg <= tx_hold`, so the interrupted frame is retransmitted.
  - `abort` pulses.
  - `tx_pending` is not consumed.
- `ss` changing to a different valid ID mid-frame is treated as an abort.

## Timing
- Reset values:
  - `cnt=0`, `shreg=tx_hold=IDLE_FILL`, `tx_buf=0`, `tx_pending=0`, `rx_data=0`.
  - Outputs: `rx_valid=0`, `tx_ready=1`, `busy=0`, `overrun=0`, `abort=0`, `miso=0` when `ss=3'b111`.
- Reset mid-frame: everything returns to reset values immediately; no partial frame is delivered.
- Latency:
  - `rx_valid` rises on the edge that samples the last bit, i.e. DATA_W edges after the first selected edge.
  - `tx_load` to `shreg`: one edge when idle; otherwise the next frame end.
  - `tx_ready` rises on the transfer edge.
- `overrun`, `abort`: registered, high for exactly one cycle.
- `busy`: registered from `cnt`.

## Structure
- Shared package `spi_pkg`:
  - `SPI_DATA_W = 6`.
  - `SS_NONE = 3'b111`.
  - Slave ID constants `SLAVE_1 = 3'b000`, `SLAVE_2 = 3'b001`, `SLAVE_3 = 3'b010`.
  - Shared with `spi_master`.
- One sub-module: `spi_rx_hold`, the one-entry valid/ready holding register with overrun detection. The shift/count logic stays in `spi_slave`.

## Test plan
- Reset, `ss=3'b111`, `SLAVE_ID=3'b010` -> `miso=0`, `rx_valid=0`, `tx_ready=1`, `busy=0`.
- Full frame exchange:
  - Setup: `tx_load` with `6'b110011` while idle; `ss=3'b010`; `mosi` drives `101101` MSB first over 6 edges.
  - `miso` sequence is `1,1,0,0,1,1`.
  - `rx_data=6'b101101` and `rx_valid=1` after edge 6.
  - `tx_ready=1` one edge after the load.
- Back-to-back frames:
  - Setup: `ss` held at 3'b010 for 12 edges, with `6'b000111` pending.
  - Second frame's `miso` is `000111`.
  - Two `rx_valid` events with `rx_ready=1`; no gap edge between frames.
- Abort:
  - Stimulus: deselect (`ss=3'b111`) after 3 edges, then reselect.
  - `abort` pulses once, no `rx_valid`, `busy` falls.
  - Resent frame starts again from the MSB of `110011`.
- Overrun and simultaneous handshake:
  - `rx_ready=0` through two frames -> `overrun` pulses at the second frame end and `rx_data` keeps the first word.
  - Repeat with `rx_ready=1` on the frame-end edge -> new word replaces the old one and `rx_valid` stays 1.
- Other-slave and reset cases:
  - `ss=3'b000` for an instance with `SLAVE_ID=3'b010` -> `miso=0`, `cnt` unchanged.
  - `reset` asserted at edge 4 of a frame -> all reset values immediately, and the next full frame is received correctly.
